// File: rtl/axi4_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
//  params_pkg / axi4_if
//  Bus widths and the AXI4 write-channel bundle (AW, W, B) shared by the
//  arbiter and its neighbours.
//  Revision: 1.0
// ============================================================================

package params_pkg;
    localparam int AXI4_ADDR_W = 32;
    localparam int AXI4_DATA_W = 32;
endpackage

interface axi4_if;
    import params_pkg::*;

    logic [AXI4_ADDR_W-1:0]   awaddr;
    logic [7:0]               awlen;
    logic [2:0]               awsize;
    logic [1:0]               awburst;
    logic                     awvalid;
    logic                     awready;

    logic [AXI4_DATA_W-1:0]   wdata;
    logic [AXI4_DATA_W/8-1:0] wstrb;
    logic                     wlast;
    logic                     wvalid;
    logic                     wready;

    logic [1:0]               bresp;
    logic                     bvalid;
    logic                     bready;

    modport master (
        output awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bresp, bvalid,
        output bready
    );

    modport slave (
        input  awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bresp, bvalid,
        input  bready
    );
endinterface

`default_nettype wire

// File: rtl/axi4_wr_arbiter.sv
`default_nettype none
// ============================================================================
//  axi4_wr_arbiter
//  Two-master AXI4 write arbiter; holds one grant across AW -> W -> B.
//  Optional macro AXI_WR_ARB_RR_EN selects round-robin tie-break (else s0 wins).
//  Revision: 1.0
// ============================================================================

module axi4_wr_arbiter #(
    parameter int BEAT_W = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    axi4_if.slave      s0,
    axi4_if.slave      s1,
    axi4_if.master     m,
    output logic [1:0] grant,
    output logic       busy,
    output logic       err_wlast
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADDR = 2'd1,
        DATA = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [1:0]         r_grant;
    logic [1:0]         w_win;
    logic [1:0]         w_req;
    logic [BEAT_W-1:0]  r_len;
    logic [BEAT_W-1:0]  r_beat_cnt;
    logic               r_err_wlast;
    logic               w_sel1;
    logic               w_aw_hs;
    logic               w_w_hs;
    logic               w_b_hs;

    assign w_req  = {s1.awvalid, s0.awvalid};
    assign w_sel1 = r_grant[1];

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
`ifdef AXI_WR_ARB_RR_EN
    logic r_last_s1;

    always_comb begin
        w_win = 2'b00;
        if (w_req == 2'b11) begin
            w_win = r_last_s1 ? 2'b01 : 2'b10;
        end else if (w_req[0]) begin
            w_win = 2'b01;
        end else if (w_req[1]) begin
            w_win = 2'b10;
        end
    end

    // Resetting to s1 hands the very first tie to s0.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_last_s1 <= 1'b1;
        end else if (w_b_hs) begin
            r_last_s1 <= r_grant[1];
        end
    end
`else
    always_comb begin
        w_win = 2'b00;
        if (w_req[0]) begin
            w_win = 2'b01;
        end else if (w_req[1]) begin
            w_win = 2'b10;
        end
    end
`endif

    // ------------------------------------------------------------------
    // Channel routing: payloads always muxed, handshakes gated by state
    // ------------------------------------------------------------------
    always_comb begin
        m.awaddr  = w_sel1 ? s1.awaddr  : s0.awaddr;
        m.awlen   = w_sel1 ? s1.awlen   : s0.awlen;
        m.awsize  = w_sel1 ? s1.awsize  : s0.awsize;
        m.awburst = w_sel1 ? s1.awburst : s0.awburst;
        m.wdata   = w_sel1 ? s1.wdata   : s0.wdata;
        m.wstrb   = w_sel1 ? s1.wstrb   : s0.wstrb;
        m.wlast   = w_sel1 ? s1.wlast   : s0.wlast;
        m.awvalid = 1'b0;
        m.wvalid  = 1'b0;
        m.bready  = 1'b0;
        s0.awready = 1'b0;
        s0.wready  = 1'b0;
        s0.bvalid  = 1'b0;
        s0.bresp   = m.bresp;
        s1.awready = 1'b0;
        s1.wready  = 1'b0;
        s1.bvalid  = 1'b0;
        s1.bresp   = m.bresp;
        case (r_state)
            ADDR: begin
                m.awvalid  = w_sel1 ? s1.awvalid : s0.awvalid;
                s0.awready = r_grant[0] & m.awready;
                s1.awready = r_grant[1] & m.awready;
            end
            DATA: begin
                m.wvalid  = w_sel1 ? s1.wvalid : s0.wvalid;
                s0.wready = r_grant[0] & m.wready;
                s1.wready = r_grant[1] & m.wready;
            end
            RESP: begin
                m.bready  = w_sel1 ? s1.bready : s0.bready;
                s0.bvalid = r_grant[0] & m.bvalid;
                s1.bvalid = r_grant[1] & m.bvalid;
            end
            default: begin
            end
        endcase
    end

    assign w_aw_hs = (r_state == ADDR) & m.awvalid & m.awready;
    assign w_w_hs  = (r_state == DATA) & m.wvalid  & m.wready;
    assign w_b_hs  = (r_state == RESP) & m.bvalid  & m.bready;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (|w_req)              w_state_nxt = ADDR;
            ADDR:    if (w_aw_hs)             w_state_nxt = DATA;
            DATA:    if (w_w_hs && m.wlast)   w_state_nxt = RESP;
            RESP:    if (w_b_hs)              w_state_nxt = IDLE;
            default:                          w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_grant     <= 2'b00;
            r_len       <= '0;
            r_beat_cnt  <= '0;
            r_err_wlast <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (|w_req) begin
                        r_grant <= w_win;
                    end
                end
                ADDR: begin
                    r_len <= BEAT_W'(m.awlen);
                    if (w_aw_hs) begin
                        r_beat_cnt <= '0;
                    end
                end
                DATA: begin
                    if (w_w_hs) begin
                        r_beat_cnt <= r_beat_cnt + BEAT_W'(1);
                        // Flag an early wlast, or a final-count beat without wlast.
                        if (m.wlast ? (r_beat_cnt != r_len) : (r_beat_cnt == r_len)) begin
                            r_err_wlast <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    if (w_b_hs) begin
                        r_grant <= 2'b00;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign grant     = r_grant;
    assign busy      = (r_state != IDLE);
    assign err_wlast = r_err_wlast;

endmodule

`default_nettype wire
